// File: rtl/uart_tx_port_if.sv
// CPU-side bus of the UART transmit port: write strobe, data and
// overflow clear from the CPU output-port stage; serial line and
// status byte back to the CPU input-port lines.
`timescale 1ns/1ps
interface uart_tx_port_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_ovf;
    logic       tx;
    logic [7:0] status;

    modport master (
        output wr_en,
        output wr_data,
        output clr_ovf,
        input  tx,
        input  status
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        input  clr_ovf,
        output tx,
        output status
    );
endinterface

// File: rtl/uart_tx_port.sv
// UART transmit port: small byte FIFO fed by CPU output-port writes,
// serialised as 8N1 frames on tx. Status byte for CPU polling is
// {count[3:0], ovf, empty, full, busy}.
// Optional even-parity bit between data and stop: define UART_TX_PARITY_EN.
`timescale 1ns/1ps
module uart_tx_port #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_port_if.slave   bus
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [3:0]    count;
    logic [3:0]    count_nxt;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          busy;
    logic          tx_q;
    state_t        state;
    logic [7:0]    shift_q;
    logic [7:0]    baud;
    logic [2:0]    bit_idx;
    logic          push;
    logic          pop;
    logic          baud_end;
`ifdef UART_TX_PARITY_EN
    logic          parity_q;
`endif

    // The registered full flag gates the write, so a pop in the same
    // cycle never rescues a write into a full FIFO.
    assign push     = bus.wr_en & ~full;
    assign pop      = (state == IDLE) & ~empty;
    assign baud_end = (baud == 8'(CLK_DIV - 1));

    assign bus.tx     = tx_q;
    assign bus.status = {count, ovf, empty, full, busy};

    // Next occupancy: simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 4'd1;
            2'b01:   count_nxt = count - 4'd1;
            default: count_nxt = count;
        endcase
    end

    // FIFO storage; data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // FIFO pointers, occupancy, registered flags and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
            full   <= 1'b0;
            empty  <= 1'b1;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == 4'(FIFO_DEPTH));
            empty <= (count_nxt == 4'd0);
            // An overflowing write beats a simultaneous clear.
            if (bus.wr_en && full) begin
                ovf <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    // Frame sequencer; tx is registered from the current state, so it
    // trails the state by one cycle and the IDLE pop cycle becomes the
    // one-bit-time-independent gap between back-to-back frames.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shift_q <= 8'd0;
            baud    <= 8'd0;
            bit_idx <= 3'd0;
            busy    <= 1'b0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE:    tx_q <= 1'b1;
                START:   tx_q <= 1'b0;
                DATA:    tx_q <= shift_q[0];
`ifdef UART_TX_PARITY_EN
                PARITY:  tx_q <= parity_q;
`endif
                STOP:    tx_q <= 1'b1;
                default: tx_q <= 1'b1;
            endcase

            case (state)
                IDLE: begin
                    if (!empty) begin
                        shift_q <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^mem[rd_ptr];
`endif
                        baud    <= 8'd0;
                        bit_idx <= 3'd0;
                        busy    <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud  <= 8'd0;
                        state <= DATA;
                    end else begin
                        baud <= baud + 8'd1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud    <= 8'd0;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud <= baud + 8'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_end) begin
                        baud  <= 8'd0;
                        state <= STOP;
                    end else begin
                        baud <= baud + 8'd1;
                    end
                end
`endif
                STOP: begin
                    if (baud_end) begin
                        baud  <= 8'd0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        baud <= baud + 8'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port: directed writes push expected bytes into a
// scoreboard queue; a UART receiver process decodes tx frames and
// compares each against the queue head. Also compiles with
// UART_TX_PARITY_EN defined.
`timescale 1ns/1ps
module tb_uart_tx_port;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_CYC = 11 * CLK_DIV;
`else
    localparam int FRAME_CYC = 10 * CLK_DIV;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    uart_tx_port_if bus();

    uart_tx_port #(
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int frames = 0;
    logic [7:0] exp_q[$];
    int start_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Receiver wait: gives up early once a reset aborts the frame.
    task automatic mon_wait(input int n, inout logic ab);
        for (int k = 0; k < n && !ab; k++) begin
            @(negedge clk);
            if (!reset) ab = 1'b1;
        end
    endtask

    // UART receiver / scoreboard checker.
    initial begin : monitor
        logic       ab;
        logic [7:0] got;
        logic [7:0] e;
        logic       par_bit;
        par_bit = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && bus.tx === 1'b0) begin
                ab = 1'b0;
                got = 8'd0;
                start_cyc.push_back(cyc);
                mon_wait(CLK_DIV / 2, ab);
                if (!ab) check("start_bit", bus.tx, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    mon_wait(CLK_DIV, ab);
                    got[i] = bus.tx;
                end
`ifdef UART_TX_PARITY_EN
                mon_wait(CLK_DIV, ab);
                par_bit = bus.tx;
`endif
                mon_wait(CLK_DIV, ab);
                if (!ab) begin
                    check("stop_bit", bus.tx, 1'b1);
                    frames++;
                    check("frame_expected", (exp_q.size() != 0), 1'b1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("rx_byte", got, e);
`ifdef UART_TX_PARITY_EN
                        check("parity_bit", par_bit, ^e);
`endif
                    end
                end
            end
        end
    end

    task automatic write_byte(input logic [7:0] d, input bit sent);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        if (sent) exp_q.push_back(d);
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((bus.status !== 8'h04 || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", (n < budget), 1'b1);
    endtask

    initial begin : global_timeout
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int bc;
        int g;
        int act;
        int f0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.clr_ovf = 1'b0;

        // Reset state and mid-run asynchronous reset, then quiet line.
        repeat (3) @(negedge clk);
        check("por_status", bus.status, 8'h04);
        check("por_tx", bus.tx, 1'b1);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_tx", bus.tx, 1'b1);
        check("rst_status", bus.status, 8'h04);
        @(negedge clk);
        reset = 1'b1;
        act = 0;
        f0 = frames;
        repeat (100) begin
            @(negedge clk);
            if (bus.tx !== 1'b1) act++;
        end
        check("idle_tx_activity", act, 0);
        check("idle_frames", frames, f0);
        check("idle_status", bus.status, 8'h04);

        // Single byte: latency and busy length.
        write_byte(8'hA5, 1'b1);
        check("lat_n_tx", bus.tx, 1'b1);
        @(negedge clk);
        check("lat_n1_tx", bus.tx, 1'b1);
        check("lat_n1_busy", bus.status[0], 1'b1);
        bc = 1;
        @(negedge clk);
        check("lat_n2_tx", bus.tx, 1'b0);
        g = 0;
        while (bus.status[0] === 1'b1 && g < 300) begin
            bc++;
            @(negedge clk);
            g++;
        end
        check("busy_cycles", bc, FRAME_CYC);
        check("after_frame_status", bus.status, 8'h04);

        // Fill and overflow: 01 transmits, 02..05 queue, 06 dropped.
        @(negedge clk);
        bus.wr_en = 1'b1;
        for (int d = 1; d <= 6; d++) begin
            bus.wr_data = 8'(d);
            if (d <= 5) exp_q.push_back(8'(d));
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        check("full_ovf_status", bus.status, 8'h4B);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h99;
        bus.clr_ovf = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
        check("ovf_set_wins", bus.status, 8'h4B);
        @(negedge clk);
        bus.clr_ovf = 1'b0;
        check("ovf_cleared", bus.status, 8'h43);
        wait_idle(8 * FRAME_CYC);

        // Push and pop on the same edge with a one-entry FIFO.
        start_cyc.delete();
        write_byte(8'hC3, 1'b1);
        write_byte(8'h5E, 1'b1);
        g = 0;
        while (bus.status[0] === 1'b1 && g < 300) begin
            @(negedge clk);
            g++;
        end
        check("pp_idle_status", bus.status, 8'h10);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h96;
        exp_q.push_back(8'h96);
        @(negedge clk);
        bus.wr_en = 1'b0;
        check("pp_count_kept", bus.status, 8'h11);
        wait_idle(5 * FRAME_CYC);
        check("pp_frames", start_cyc.size(), 3);
        if (start_cyc.size() == 3) begin
            check("gap_1", start_cyc[1] - start_cyc[0], FRAME_CYC + 1);
            check("gap_2", start_cyc[2] - start_cyc[1], FRAME_CYC + 1);
        end

        // Reset during data bit 3 (0x33 sends 1,1,0,0 first, so tx is low).
        write_byte(8'h33, 1'b1);
        write_byte(8'h77, 1'b1);
        g = 0;
        while (bus.tx !== 1'b0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        repeat (4 * CLK_DIV + 1) @(negedge clk);
        check("bit3_low", bus.tx, 1'b0);
        #2 reset = 1'b0;
        #1;
        exp_q.delete();
        check("midframe_rst_tx", bus.tx, 1'b1);
        check("midframe_rst_status", bus.status, 8'h04);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        write_byte(8'h3C, 1'b1);
        wait_idle(3 * FRAME_CYC);

`ifdef UART_TX_PARITY_EN
        // Parity frames: 07 -> parity 1, 03 -> parity 0.
        write_byte(8'h07, 1'b1);
        bc = 0;
        g = 0;
        while (bus.status[0] !== 1'b1 && g < 5) begin
            @(negedge clk);
            g++;
        end
        while (bus.status[0] === 1'b1 && g < 300) begin
            bc++;
            @(negedge clk);
            g++;
        end
        check("parity_frame_len", bc, 44);
        write_byte(8'h03, 1'b1);
        wait_idle(3 * FRAME_CYC);
`endif

        repeat (10) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
